// File: rtl/regfile_mp_if.sv
// Register-file access bundle: decode read/mark side, write-back and load-return write side.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] i_rd_addr;
  logic [NUM_RD-1:0]        i_rd_valid;
  logic [NUM_RD*DATA_W-1:0] o_rd_data;
  logic [NUM_RD-1:0]        o_rd_busy;
  logic                     o_stall;
  logic                     i_wa_en;
  logic [ADDR_W-1:0]        i_wa_addr;
  logic [DATA_W-1:0]        i_wa_data;
  logic                     i_wb_en;
  logic [ADDR_W-1:0]        i_wb_addr;
  logic [DATA_W-1:0]        i_wb_data;
  logic                     i_mark_en;
  logic [ADDR_W-1:0]        i_mark_addr;
  logic                     i_flush;
  logic                     o_wr_conflict;
  logic [ADDR_W:0]          o_pending;

  modport master (
    output i_rd_addr, i_rd_valid, i_wa_en, i_wa_addr, i_wa_data,
           i_wb_en, i_wb_addr, i_wb_data, i_mark_en, i_mark_addr, i_flush,
    input  o_rd_data, o_rd_busy, o_stall, o_wr_conflict, o_pending
  );

  modport slave (
    input  i_rd_addr, i_rd_valid, i_wa_en, i_wa_addr, i_wa_data,
           i_wb_en, i_wb_addr, i_wb_data, i_mark_en, i_mark_addr, i_flush,
    output o_rd_data, o_rd_busy, o_stall, o_wr_conflict, o_pending
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: ALU and load-return write ports, bypassed reads,
// optional hard-wired zero entry and a load-use busy scoreboard.
module regfile_mp #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic         i_clk,
  input logic         i_rst_n,
  regfile_mp_if.slave bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam bit          ZR    = (ZERO_REG != 0);
  localparam bit          BP    = (BYPASS != 0);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]             busy_q, busy_d;
  logic                         conflict_q, conflict_d;
  logic [CNT_W-1:0]             pending_q, pending_d;
  logic                         wa_ok, wb_ok, mark_ok;

  logic [ADDR_W-1:0]            ra_c [NUM_RD];
  logic [NUM_RD*DATA_W-1:0]     rd_data_c;
  logic [NUM_RD-1:0]            rd_busy_c;

  // Write commit, scoreboard update (flush, then load clear, then mark) and popcount
  always_comb begin
    wa_ok      = bus.i_wa_en && !(ZR && (bus.i_wa_addr == ADDR_W'(0)));
    wb_ok      = bus.i_wb_en && !(ZR && (bus.i_wb_addr == ADDR_W'(0)));
    mark_ok    = bus.i_mark_en && !(ZR && (bus.i_mark_addr == ADDR_W'(0)));
    conflict_d = wa_ok && wb_ok && (bus.i_wa_addr == bus.i_wb_addr);

    mem_d = mem_q;
    if (wb_ok && !conflict_d) mem_d[bus.i_wb_addr] = bus.i_wb_data;
    if (wa_ok)                mem_d[bus.i_wa_addr] = bus.i_wa_data;

    busy_d = busy_q;
    if (bus.i_flush) busy_d = '0;
    if (wb_ok)       busy_d[bus.i_wb_addr]   = 1'b0;
    if (mark_ok)     busy_d[bus.i_mark_addr] = 1'b1;

    pending_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pending_d = pending_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem_q      <= '0;
      busy_q     <= '0;
      conflict_q <= 1'b0;
      pending_q  <= '0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      pending_q  <= pending_d;
    end
  end

  // Combinational read ports; port A data takes priority over the load return
  always_comb begin
    rd_data_c = '0;
    rd_busy_c = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      ra_c[p] = bus.i_rd_addr[p*ADDR_W +: ADDR_W];
      rd_data_c[p*DATA_W +: DATA_W] = mem_q[ra_c[p]];
      rd_busy_c[p] = busy_q[ra_c[p]];
      if (BP && bus.i_wb_en && (bus.i_wb_addr == ra_c[p])) begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.i_wb_data;
        rd_busy_c[p] = 1'b0;
      end
      if (BP && bus.i_wa_en && (bus.i_wa_addr == ra_c[p])) begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.i_wa_data;
      end
      if ((ZR && (ra_c[p] == ADDR_W'(0))) || !i_rst_n) begin
        rd_data_c[p*DATA_W +: DATA_W] = '0;
        rd_busy_c[p] = 1'b0;
      end
    end
  end

  assign bus.o_rd_data     = rd_data_c;
  assign bus.o_rd_busy     = rd_busy_c;
  assign bus.o_stall       = |(bus.i_rd_valid & rd_busy_c);
  assign bus.o_wr_conflict = conflict_q;
  assign bus.o_pending     = pending_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass+zero reg, and neither) driven
// identically and compared each cycle against an array-based model.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_valid;
  logic        wa_en, wb_en, mark_en, flush;
  logic [4:0]  wa_addr, wb_addr, mark_addr;
  logic [63:0] wa_data, wb_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // model state: index 0 = BYPASS=1/ZERO_REG=1 instance, 1 = BYPASS=0/ZERO_REG=0
  logic [63:0] m_mem  [2][32];
  bit          m_busy [2][32];
  bit          m_conf [2];
  int          m_pend [2];

  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bz ();
  regfile_mp_if #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2)) bn ();

  always_comb begin
    bz.i_rd_addr = rd_addr;  bz.i_rd_valid = rd_valid;
    bz.i_wa_en = wa_en;      bz.i_wa_addr = wa_addr;     bz.i_wa_data = wa_data;
    bz.i_wb_en = wb_en;      bz.i_wb_addr = wb_addr;     bz.i_wb_data = wb_data;
    bz.i_mark_en = mark_en;  bz.i_mark_addr = mark_addr; bz.i_flush = flush;
    bn.i_rd_addr = rd_addr;  bn.i_rd_valid = rd_valid;
    bn.i_wa_en = wa_en;      bn.i_wa_addr = wa_addr;     bn.i_wa_data = wa_data;
    bn.i_wb_en = wb_en;      bn.i_wb_addr = wb_addr;     bn.i_wb_data = wb_data;
    bn.i_mark_en = mark_en;  bn.i_mark_addr = mark_addr; bn.i_flush = flush;
  end

  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bz.slave));
  regfile_mp #(.DATA_W(64), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_n (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bn.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  function automatic logic [63:0] exp_data(int c, logic [4:0] a);
    if (!rst_n) return 64'h0;
    if (c == 0) begin
      if (a == 5'd0) return 64'h0;
      if (wa_en && wa_addr == a) return wa_data;
      if (wb_en && wb_addr == a) return wb_data;
    end
    return m_mem[c][a];
  endfunction

  function automatic bit exp_busy(int c, logic [4:0] a);
    if (!rst_n) return 1'b0;
    if (c == 0 && (a == 5'd0 || (wb_en && wb_addr == a))) return 1'b0;
    return m_busy[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[c][i]  = 64'h0;
        m_busy[c][i] = 1'b0;
      end
      m_conf[c] = 1'b0;
      m_pend[c] = 0;
    end
  endtask

  // edge behaviour from the rules: zero entry ignored, A wins data, busy flush/clear/mark
  task automatic model_edge();
    bit z, wa_ok, wb_ok, mk_ok;
    if (!rst_n) return;
    for (int c = 0; c < 2; c++) begin
      z     = (c == 0);
      wa_ok = wa_en && !(z && wa_addr == 5'd0);
      wb_ok = wb_en && !(z && wb_addr == 5'd0);
      mk_ok = mark_en && !(z && mark_addr == 5'd0);
      m_conf[c] = wa_ok && wb_ok && wa_addr == wb_addr;
      if (wa_ok) m_mem[c][wa_addr] = wa_data;
      else if (wb_ok) m_mem[c][wb_addr] = wb_data;
      if (wb_ok && !(wa_ok && wa_addr == wb_addr)) m_mem[c][wb_addr] = wb_data;
      if (flush) for (int i = 0; i < 32; i++) m_busy[c][i] = 1'b0;
      if (wb_ok) m_busy[c][wb_addr] = 1'b0;
      if (mk_ok) m_busy[c][mark_addr] = 1'b1;
      m_pend[c] = 0;
      for (int i = 0; i < 32; i++) m_pend[c] += int'(m_busy[c][i]);
    end
  endtask

  task automatic compare_all();
    logic [127:0] d;
    logic [1:0]   b;
    logic         s, cf;
    logic [5:0]   pd;
    bit           es;
    logic [4:0]   a;
    for (int c = 0; c < 2; c++) begin
      d  = (c == 0) ? bz.o_rd_data : bn.o_rd_data;
      b  = (c == 0) ? bz.o_rd_busy : bn.o_rd_busy;
      s  = (c == 0) ? bz.o_stall : bn.o_stall;
      cf = (c == 0) ? bz.o_wr_conflict : bn.o_wr_conflict;
      pd = (c == 0) ? bz.o_pending : bn.o_pending;
      es = 1'b0;
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*5 +: 5];
        chk($sformatf("cfg%0d rd_data[%0d] a=%0d", c, p, a), d[p*64 +: 64], exp_data(c, a));
        chk($sformatf("cfg%0d rd_busy[%0d] a=%0d", c, p, a), 64'(b[p]), 64'(exp_busy(c, a)));
        es = es | (rd_valid[p] & exp_busy(c, a));
      end
      chk($sformatf("cfg%0d stall", c), 64'(s), 64'(es));
      chk($sformatf("cfg%0d wr_conflict", c), 64'(cf), 64'(m_conf[c]));
      chk($sformatf("cfg%0d pending", c), 64'(pd), 64'(m_pend[c]));
    end
  endtask

  task automatic step();
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rd_addr = '0; rd_valid = '0;
    wa_en = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    mark_en = 0; mark_addr = '0; flush = 0;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    model_reset();
    // reset held with active writes: outputs must read 0
    wa_en = 1; wa_addr = 5'd5; wa_data = 64'hDEAD; rd_addr = {5'd5, 5'd5}; rd_valid = 2'b11;
    step();
    step();
    idle();
    rst_n = 1'b1;

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)}; rd_valid = 2'b11;
      step();
    end
    chk("post-reset pending z", 64'(bz.o_pending), 64'h0);
    chk("post-reset stall z", 64'(bz.o_stall), 64'h0);

    // same-cycle write A and read
    idle(); wa_en = 1; wa_addr = 5'd5; wa_data = 64'h1234; rd_addr = {5'd0, 5'd5};
    #1;
    chk("bypass r5 z", bz.o_rd_data[63:0], 64'h1234);
    chk("nobypass r5 n", bn.o_rd_data[63:0], 64'h0);
    step();
    idle(); rd_addr = {5'd0, 5'd5};
    #1;
    chk("array r5 n", bn.o_rd_data[63:0], 64'h1234);
    step();

    // zero register ignores write and mark
    idle(); wa_en = 1; wa_addr = 5'd0; wa_data = 64'hFFFF; step();
    idle(); mark_en = 1; mark_addr = 5'd0; step();
    idle(); rd_addr = {5'd0, 5'd0}; rd_valid = 2'b01;
    #1;
    chk("r0 data z", bz.o_rd_data[63:0], 64'h0);
    chk("r0 busy z", 64'(bz.o_rd_busy), 64'h0);
    chk("r0 pending z", 64'(bz.o_pending), 64'h0);
    chk("r0 data n", bn.o_rd_data[63:0], 64'hFFFF);
    step();

    // write conflict: A wins
    idle(); wa_en = 1; wa_addr = 5'd7; wa_data = 64'hAA; wb_en = 1; wb_addr = 5'd7; wb_data = 64'hBB;
    rd_addr = {5'd0, 5'd7};
    #1;
    chk("conflict bypass z", bz.o_rd_data[63:0], 64'hAA);
    step();
    idle(); rd_addr = {5'd0, 5'd7};
    #1;
    chk("conflict pulse z", 64'(bz.o_wr_conflict), 64'h1);
    chk("conflict array n", bn.o_rd_data[63:0], 64'hAA);
    step();
    #1;
    chk("conflict drop z", 64'(bz.o_wr_conflict), 64'h0);
    step();

    // load-use hazard
    idle(); mark_en = 1; mark_addr = 5'd3; step();
    idle(); rd_addr = {5'd0, 5'd3}; rd_valid = 2'b01; wa_en = 1; wa_addr = 5'd3; wa_data = 64'h77;
    #1;
    chk("hazard stall z", 64'(bz.o_stall), 64'h1);
    step();
    idle(); rd_addr = {5'd0, 5'd3}; rd_valid = 2'b01; wb_en = 1; wb_addr = 5'd3; wb_data = 64'h55;
    #1;
    chk("return stall z", 64'(bz.o_stall), 64'h0);
    chk("return data z", bz.o_rd_data[63:0], 64'h55);
    chk("return pending z", 64'(bz.o_pending), 64'h1);
    chk("return stall n", 64'(bn.o_stall), 64'h1);
    chk("return data n", bn.o_rd_data[63:0], 64'h77);
    step();
    idle(); rd_addr = {5'd0, 5'd3};
    #1;
    chk("cleared pending z", 64'(bz.o_pending), 64'h0);
    step();

    // flush vs mark ordering
    idle(); mark_en = 1; mark_addr = 5'd1; step();
    mark_addr = 5'd2; step();
    mark_addr = 5'd4; step();
    idle(); flush = 1; mark_en = 1; mark_addr = 5'd9;
    #1;
    chk("three marks pending z", 64'(bz.o_pending), 64'h3);
    step();
    idle(); mark_en = 1; mark_addr = 5'd9; wb_en = 1; wb_addr = 5'd9; wb_data = 64'h99;
    #1;
    chk("flush+mark pending z", 64'(bz.o_pending), 64'h1);
    step();
    idle(); rd_addr = {5'd1, 5'd9}; rd_valid = 2'b11;
    #1;
    chk("mark beats clear busy z", 64'(bz.o_rd_busy), 64'h1);
    chk("mark beats clear pending z", 64'(bz.o_pending), 64'h1);
    step();

    // randomized traffic with occasional flush and mid-run reset
    for (int n = 0; n < 3000; n++) begin
      rst_n    = 1'b1;
      rd_addr  = {raddr(), raddr()};
      rd_valid = 2'($urandom_range(0, 3));
      wa_en    = ($urandom_range(0, 1) == 0);
      wa_addr  = raddr();
      wa_data  = {32'($urandom), 32'($urandom)};
      wb_en    = ($urandom_range(0, 4) < 2);
      wb_addr  = raddr();
      wb_data  = {32'($urandom), 32'($urandom)};
      mark_en  = ($urandom_range(0, 9) < 3);
      mark_addr = raddr();
      flush    = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
